lrc_frame_checker: RTL and testbench

Receive-side companion to the team's LRC generator: consumes a byte stream of framed messages (start byte, length, payload, LRC byte) and reports for each frame whether the trailing LRC matches the payload. It sits directly downstream of the LRC stage in the TinyTapeout top, taking bytes from `ui_in` with a valid strobe and driving status onto `uo_out`/`uio_out`. It is a single-clock, fully synchronous byte-per-cycle FSM with an inter-byte timeout.

---
 rtl/lrc_frame_checker.sv | 122 ++++++++++++
 tb/tb_lrc_frame_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lrc_frame_checker.sv
// rtl/lrc_frame_checker.sv - checks SOF/length/payload/LRC framed byte stream
// and reports one status pulse per finished or aborted frame.
module lrc_frame_checker #(
  parameter logic [7:0] SOF     = 8'h3A,
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       done,
  output logic       ok,
  output logic [1:0] err_code,
  output logic [7:0] calc_lrc,
  output logic       busy
);

  localparam int         TW      = $clog2(TIMEOUT);
  localparam logic [7:0] MAX_L   = 8'(MAX_LEN);
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_LRC = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_LEN = 2'b11;

  typedef enum logic [1:0] {HUNT, LEN, DATA, CHK} state_t;

  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      rem_q, rem_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            done_d, ok_d;
  logic [1:0]      err_d;
  logic [7:0]      lrc_d;
  logic [7:0]      neg_acc;

  assign neg_acc = 8'(8'd0 - acc_q);
  assign busy    = (state_q != HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      acc_q    <= 8'd0;
      rem_q    <= 8'd0;
      timer_q  <= '0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err_code <= ERR_OK;
      calc_lrc <= 8'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
      done     <= done_d;
      ok       <= ok_d;
      err_code <= err_d;
      calc_lrc <= lrc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    ok_d    = ok;
    err_d   = err_code;
    lrc_d   = calc_lrc;

    if (state_q == HUNT) begin
      if (in_valid && in_data == SOF) begin
        state_d = LEN;
        acc_d   = 8'd0;
        rem_d   = 8'd0;
        timer_d = '0;
      end
    end else if (in_valid) begin
      timer_d = '0;
      case (state_q)
        LEN: begin
          if (in_data > MAX_L) begin
            state_d = HUNT;
            done_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = ERR_LEN;
            lrc_d   = neg_acc;
          end else if (in_data == 8'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
            rem_d   = in_data;
          end
        end
        DATA: begin
          acc_d = acc_q + in_data;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = CHK;
        end
        default: begin
          // CHK: trailing byte compared against the negated payload sum
          state_d = HUNT;
          done_d  = 1'b1;
          ok_d    = (in_data == neg_acc);
          err_d   = (in_data == neg_acc) ? ERR_OK : ERR_LRC;
          lrc_d   = neg_acc;
        end
      endcase
    end else if (timer_q == TW'(TIMEOUT - 1)) begin
      state_d = HUNT;
      timer_d = '0;
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = ERR_TO;
      lrc_d   = neg_acc;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_lrc_frame_checker.sv
// tb/tb_lrc_frame_checker.sv - vector table, corner sequences and random
// frames checked against an arithmetic LRC model.
module tb_lrc_frame_checker;

  localparam int TMO = 8;
  localparam int MXL = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       done, ok, busy;
  logic [1:0] err_code;
  logic [7:0] calc_lrc;

  int checks = 0;
  int errors = 0;
  int ndone;
  logic       cap_ok;
  logic [1:0] cap_err;
  logic [7:0] cap_lrc;

  lrc_frame_checker #(.SOF(8'h3A), .MAX_LEN(MXL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .done(done), .ok(ok), .err_code(err_code), .calc_lrc(calc_lrc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] b [10];
    logic       exp_ok;
    logic [1:0] exp_err;
    logic [7:0] exp_lrc;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle from a falling edge; return at the next falling edge.
  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    if (done) begin
      ndone++;
      cap_ok  = ok;
      cap_err = err_code;
      cap_lrc = calc_lrc;
    end
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, TMO - 1)) drive(1'b0, 8'h00);
  endtask

  task automatic setv(input int k, input int n, input logic [79:0] bytes_msb,
                      input logic eo, input logic [1:0] ee, input logic [7:0] el);
    vt[k].n = n;
    for (int i = 0; i < 10; i++) vt[k].b[i] = bytes_msb[79 - 8*i -: 8];
    vt[k].exp_ok = eo; vt[k].exp_err = ee; vt[k].exp_lrc = el;
  endtask

  initial begin
    setv(0, 6, 80'h3A03010203FA_00000000, 1'b1, 2'b00, 8'hFA);
    setv(1, 6, 80'h3A03010203FB_00000000, 1'b0, 2'b01, 8'hFA);
    setv(2, 3, 80'h3A0000_00000000000000, 1'b1, 2'b00, 8'h00);
    setv(3, 8, 80'h55AA003A02FF02FF_0000, 1'b1, 2'b00, 8'hFF);
    setv(4, 4, 80'h3A013AC6_000000000000, 1'b1, 2'b00, 8'hC6);
    setv(5, 2, 80'h3A41_0000000000000000, 1'b0, 2'b11, 8'h00);
    setv(6, 4, 80'h3A0105FB_000000000000, 1'b1, 2'b00, 8'hFB);
    setv(7, 5, 80'h3A02808000_0000000000, 1'b1, 2'b00, 8'h00);
    setv(8, 5, 80'h3A023A3A8C_0000000000, 1'b1, 2'b00, 8'h8C);

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ndone = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_ok", ok, 0);
    chk("rst_err", err_code, 0);
    chk("rst_lrc", calc_lrc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: all entries streamed back-to-back with no idle cycle.
    for (int e = 0; e < 9; e++) begin
      logic started;
      started = 1'b0;
      for (int i = 0; i < vt[e].n; i++) begin
        if (vt[e].b[i] == 8'h3A) started = 1'b1;
        drive(1'b1, vt[e].b[i]);
        chk($sformatf("v%0d_done_%0d", e, i), done, (i == vt[e].n - 1));
        chk($sformatf("v%0d_busy_%0d", e, i), busy, started && (i != vt[e].n - 1));
      end
      chk($sformatf("v%0d_ok", e), ok, vt[e].exp_ok);
      chk($sformatf("v%0d_err", e), err_code, vt[e].exp_err);
      chk($sformatf("v%0d_lrc", e), calc_lrc, vt[e].exp_lrc);
    end

    // Timeout: 8 idle cycles after the 0x10 byte abort the frame.
    drive(1'b1, 8'h3A); drive(1'b1, 8'h02); drive(1'b1, 8'h10);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("to_done_c%0d", c), done, (c == 9));
      if (c < 9) drive(1'b0, 8'h00);
    end
    chk("to_err", err_code, 2'b10);
    chk("to_ok", ok, 0);
    chk("to_lrc", calc_lrc, 8'hF0);
    chk("to_busy", busy, 0);

    // Seven-cycle gap must not abort.
    ndone = 0;
    drive(1'b1, 8'h3A); drive(1'b1, 8'h02); drive(1'b1, 8'h10);
    repeat (7) drive(1'b0, 8'h00);
    drive(1'b1, 8'h20);
    repeat (7) drive(1'b0, 8'h00);
    chk("gap_nodone", ndone, 0);
    drive(1'b1, 8'hD0);
    chk("gap_ndone", ndone, 1);
    chk("gap_ok", ok, 1);
    chk("gap_lrc", calc_lrc, 8'hD0);

    // Reset mid-frame.
    ndone = 0;
    drive(1'b1, 8'h3A); drive(1'b1, 8'h03); drive(1'b1, 8'h01);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ok", ok, 0);
    chk("mrst_lrc", calc_lrc, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err_code, 0);
    repeat (2) drive(1'b0, 8'h00);
    rst_n = 1'b1;
    chk("mrst_nodone", ndone, 0);
    drive(1'b1, 8'h3A); drive(1'b1, 8'h01); drive(1'b1, 8'h05); drive(1'b1, 8'hFB);
    chk("mrst_ndone", ndone, 1);
    chk("mrst_after_ok", cap_ok, 1);

    // Random frames against the arithmetic model.
    for (int f = 0; f < 60; f++) begin
      int len, sum, cut, nj;
      logic trunc, good;
      logic [7:0] p, lrc_exp, cb;
      logic [1:0] err_exp;
      logic ok_exp;
      ndone = 0;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        p = 8'($urandom);
        if (p == 8'h3A) p = 8'h3B;
        drive(1'b1, p);
        if ($urandom_range(0, 1) == 1) drive(1'b0, 8'h00);
      end
      drive(1'b1, 8'h3A);
      len = $urandom_range(0, 80);
      gap();
      drive(1'b1, 8'(len));
      sum = 0;
      if (len > MXL) begin
        ok_exp = 1'b0; err_exp = 2'b11; lrc_exp = 8'h00;
      end else begin
        trunc = ($urandom_range(0, 7) == 0);
        cut = $urandom_range(0, len);
        for (int i = 0; i < len; i++) begin
          if (trunc && i == cut) break;
          gap();
          p = 8'($urandom);
          sum += p;
          drive(1'b1, p);
        end
        lrc_exp = 8'((256 - (sum % 256)) % 256);
        if (trunc) begin
          repeat (TMO) drive(1'b0, 8'h00);
          ok_exp = 1'b0; err_exp = 2'b10;
        end else begin
          gap();
          good = 1'($urandom_range(0, 1));
          cb = good ? lrc_exp : (lrc_exp ^ (8'h01 << $urandom_range(0, 7)));
          drive(1'b1, cb);
          ok_exp = good; err_exp = good ? 2'b00 : 2'b01;
        end
      end
      chk($sformatf("r%0d_ndone", f), ndone, 1);
      chk($sformatf("r%0d_ok", f), cap_ok, ok_exp);
      chk($sformatf("r%0d_err", f), cap_err, err_exp);
      chk($sformatf("r%0d_lrc", f), cap_lrc, lrc_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
